// File: rtl/display_fetch_scheduler_if.sv
// display_fetch_scheduler_if: memory read port and line buffer write port of the display fetcher
interface display_fetch_scheduler_if #(parameter int ADDR_W = 22);
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_ack;
  logic [15:0]       mem_rdata;
  logic              lb_we;
  logic [8:0]        lb_waddr;
  logic [15:0]       lb_wdata;
  modport master(output mem_req, mem_addr, lb_we, lb_waddr, lb_wdata, input mem_ack, mem_rdata);
  modport slave(input mem_req, mem_addr, lb_we, lb_waddr, lb_wdata, output mem_ack, mem_rdata);
endinterface

// File: rtl/display_fetch_scheduler.sv
// display_fetch_scheduler: fetches one display line per qualified hsync into a double-banked line buffer
module display_fetch_scheduler #(
  parameter int LINE_WORDS = 192,
  parameter int ADDR_W     = 22
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         hs_pulse,
  input  logic                         vs_pulse,
  input  logic                         fetch_line,
  input  logic                         cfg_enable,
  input  logic [ADDR_W-1:0]            cfg_base,
  display_fetch_scheduler_if.master    bus,
  output logic                         busy,
  output logic                         underrun,
  output logic [7:0]                   underrun_cnt
);
  typedef enum logic {IDLE, FETCH} state_t;
  state_t            state;
  logic              sh_en;
  logic              bank;
  logic [7:0]        idx;
  logic [ADDR_W-1:0] line_addr;
  logic              en_now;
  logic [ADDR_W-1:0] addr_now;
  logic              start;
  logic              counted;
  logic              last;
  logic              abort;
  // vsync reloads the shadows in the same cycle, so a line-0 start sees the new frame settings
  always_comb begin
    en_now   = vs_pulse ? cfg_enable : sh_en;
    addr_now = vs_pulse ? cfg_base : line_addr;
    start    = hs_pulse && fetch_line && en_now;
    counted  = (state == FETCH) && bus.mem_req && bus.mem_ack;
    last     = counted && (idx == 8'(LINE_WORDS - 1));
    abort    = start && (state == FETCH) && !last;
  end
  assign busy = (state == FETCH);
  // fetch FSM: a new start overrides completion and word stepping; a line finishing on the start cycle is not an underrun
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state         <= IDLE;
      sh_en         <= 1'b0;
      bank          <= 1'b0;
      idx           <= '0;
      line_addr     <= '0;
      underrun      <= 1'b0;
      underrun_cnt  <= '0;
      bus.mem_req   <= 1'b0;
      bus.mem_addr  <= '0;
      bus.lb_we     <= 1'b0;
      bus.lb_waddr  <= '0;
      bus.lb_wdata  <= '0;
    end else begin
      bus.lb_we <= counted;
      underrun  <= abort;
      if (counted) begin
        bus.lb_wdata <= bus.mem_rdata;
        bus.lb_waddr <= {bank, idx};
        bus.mem_addr <= bus.mem_addr + 1'b1;
        idx          <= idx + 1'b1;
      end
      if (last) begin
        state       <= IDLE;
        bus.mem_req <= 1'b0;
      end
      if (vs_pulse) begin
        sh_en        <= cfg_enable;
        line_addr    <= cfg_base;
        underrun_cnt <= '0;
      end else if (abort && underrun_cnt != 8'hff) begin
        underrun_cnt <= underrun_cnt + 1'b1;
      end
      if (start) begin
        bus.mem_addr <= addr_now;
        line_addr    <= addr_now + ADDR_W'(LINE_WORDS);
        idx          <= '0;
        bank         <= ~bank;
        state        <= FETCH;
        bus.mem_req  <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_display_fetch_scheduler.sv
// tb_display_fetch_scheduler: directed scenarios plus random traffic checked against a line-level model
module tb_display_fetch_scheduler;
  localparam int LW = 192;
  localparam int AW = 22;
  logic          clk = 1'b0;
  logic          reset_n;
  logic          hs;
  logic          vs;
  logic          fl;
  logic          en;
  logic [AW-1:0] base;
  logic          busy;
  logic          underrun;
  logic [7:0]    ucnt;
  int            n_chk = 0;
  int            n_pass = 0;
  int            ack_div = 1;
  int            cyc = 0;
  bit            m_act, m_bank, m_shen, e_we, e_ur;
  logic [AW-1:0] m_start, m_line;
  int            m_done, m_cnt;
  logic [8:0]    e_waddr;
  logic [15:0]   e_wdata;
  always #5 clk = ~clk;
  display_fetch_scheduler_if #(.ADDR_W(AW)) bus ();
  display_fetch_scheduler #(.LINE_WORDS(LW), .ADDR_W(AW)) dut (
    .clk(clk), .reset_n(reset_n), .hs_pulse(hs), .vs_pulse(vs), .fetch_line(fl),
    .cfg_enable(en), .cfg_base(base), .bus(bus), .busy(busy), .underrun(underrun),
    .underrun_cnt(ucnt)
  );
  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got %h want %h at cycle %0d", tag, got, exp, cyc);
  endtask
  // one clock: line-level model update from current inputs, then compare all outputs
  task automatic step();
    bit counted, start;
    bus.mem_rdata = 16'($urandom);
    bus.mem_ack = (ack_div == 0) ? 1'($urandom_range(0, 1)) : (cyc % ack_div == 0);
    e_we = 0;
    e_ur = 0;
    if (!reset_n) begin
      m_act = 0; m_bank = 0; m_shen = 0; m_start = '0; m_line = '0; m_done = 0; m_cnt = 0;
    end else begin
      counted = m_act && bus.mem_ack;
      e_we = counted;
      if (counted) begin
        e_waddr = {m_bank, 8'(m_done)};
        e_wdata = bus.mem_rdata;
        m_done++;
        if (m_done == LW) m_act = 0;
      end
      if (vs) begin
        m_shen = en; m_line = base; m_cnt = 0;
      end
      start = hs && fl && m_shen;
      if (start) begin
        e_ur = m_act;
        if (e_ur && !vs && m_cnt < 255) m_cnt++;
        m_start = m_line; m_line = m_line + AW'(LW); m_done = 0; m_bank = ~m_bank; m_act = 1;
      end
    end
    @(posedge clk);
    #1;
    cyc++;
    check("mem_req", bus.mem_req, m_act);
    check("mem_addr", bus.mem_addr, m_start + AW'(m_done));
    check("busy", busy, m_act);
    check("lb_we", bus.lb_we, e_we);
    if (e_we) begin
      check("lb_waddr", bus.lb_waddr, e_waddr);
      check("lb_wdata", bus.lb_wdata, e_wdata);
    end
    check("underrun", underrun, e_ur);
    check("underrun_cnt", ucnt, m_cnt);
  endtask
  task automatic run(int n);
    repeat (n) step();
  endtask
  task automatic line(bit v, bit f);
    vs = v; hs = 1; fl = f;
    step();
    vs = 0; hs = 0; fl = 0;
  endtask
  initial begin
    reset_n = 0; hs = 0; vs = 0; fl = 0; en = 0; base = '0;
    run(3);
    check("rst_lb_waddr", bus.lb_waddr, 0);
    check("rst_lb_wdata", bus.lb_wdata, 0);
    reset_n = 1;
    base = AW'(32'h1000); en = 1;
    line(1, 1);
    check("first_addr", bus.mem_addr, 32'h1000);
    run(200);
    line(0, 1);
    check("second_addr", bus.mem_addr, 32'h10c0);
    run(200);
    ack_div = 4;
    line(0, 1);
    run(299);
    line(0, 1);
    check("underrun_one", ucnt, 1);
    run(20);
    line(1, 0);
    run(800);
    ack_div = 1;
    line(0, 1);
    run(50);
    base = AW'(32'h2000);
    run(150);
    line(0, 1);
    run(200);
    line(1, 1);
    check("new_base", bus.mem_addr, 32'h2000);
    run(200);
    line(0, 1);
    run(30);
    reset_n = 0;
    step();
    reset_n = 1;
    line(0, 1);
    run(10);
    line(1, 1);
    run(200);
    ack_div = 0;
    repeat (300) begin
      line(0, 1);
      run(2);
    end
    check("cnt_saturated", ucnt, 255);
    run(400);
    repeat (4000) begin
      hs = ($urandom_range(0, 199) == 0);
      vs = hs && ($urandom_range(0, 7) == 0);
      fl = 1'($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 499) == 0) en = ~en;
      if ($urandom_range(0, 299) == 0) base = AW'($urandom);
      reset_n = ($urandom_range(0, 2999) != 0);
      step();
    end
    reset_n = 1; hs = 0; vs = 0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/display_fetch_scheduler.md
DISPLAY_FETCH_SCHEDULER -- requirements
Module: display_fetch_scheduler

Interface
REQ-001 SHALL have parameter LINE_WORDS, default 192, meaning 16-bit words fetched per active line (384 px at 8 bpp).
REQ-002 SHALL have parameter ADDR_W, default 22, meaning word-address width of display memory.
REQ-003 SHALL have port clk  input  1  single clock; all logic on posedge.
REQ-004 SHALL have port reset_n  input  1  synchronous, active-low reset.
REQ-005 SHALL have port hs_pulse  input  1  one-cycle strobe at start of each line (video_x wraps to 0).
REQ-006 SHALL have port vs_pulse  input  1  one-cycle strobe at start of frame; coincides with hs_pulse of line 0.
REQ-007 SHALL have port fetch_line  input  1  qualifies hs_pulse: the upcoming line is an active display line.
REQ-008 SHALL have port cfg_enable  input  1  display DMA enable, CPU domain, shadowed.
REQ-009 SHALL have port cfg_base  input  ADDR_W  frame buffer start word address, shadowed.
REQ-010 SHALL have port mem_req  output  1  memory request, held high while fetching.
REQ-011 SHALL have port mem_addr  output  ADDR_W  word address of current request.
REQ-012 SHALL have port mem_ack  input  1  one word accepted/returned this cycle.
REQ-013 SHALL have port mem_rdata  input  16  read data, valid with mem_ack.
REQ-014 SHALL have port lb_we  output  1  line buffer write strobe.
REQ-015 SHALL have port lb_waddr  output  9  {bank, word index[7:0]}.
REQ-016 SHALL have port lb_wdata  output  16  line buffer write data.
REQ-017 SHALL have port busy  output  1  FSM in FETCH.
REQ-018 SHALL have port underrun  output  1  one-cycle pulse when a fetch is aborted.
REQ-019 SHALL have port underrun_cnt  output  8  saturating count of underruns in the current frame.

Function
REQ-020 SHALL load shadow enable/base from cfg_enable/cfg_base only on vs_pulse; mid-frame cfg changes have no effect.
REQ-021 SHALL, on vs_pulse, set line_addr to the new shadow base and clear underrun_cnt to 0 (same cycle).
REQ-022 SHALL implement FSM states IDLE and FETCH.
REQ-023 SHALL start a fetch on hs_pulse when fetch_line and shadow enable are 1 (vs_pulse evaluated first when simultaneous): mem_addr <= line_addr, line_addr += LINE_WORDS, word index <= 0, bank toggles, state FETCH, mem_req=1 next cycle.
REQ-024 SHALL, in FETCH, count a word only when mem_req=1 and mem_ack=1; mem_ack while mem_req=0 ignored.
REQ-025 SHALL increment mem_addr by 1 on each counted word (modulo 2^ADDR_W wrap).
REQ-026 SHALL register each counted word: lb_we=1, lb_wdata=mem_rdata, lb_waddr={bank, index} one cycle after the mem_ack (latency 1).
REQ-027 SHALL return to IDLE after the LINE_WORDS-th counted word; mem_req low the following cycle.
REQ-028 SHALL, on a start condition while in FETCH, pulse underrun, saturating-increment underrun_cnt (stop at 255), abandon remaining words, and start the new fetch per REQ-023 in the same cycle.
REQ-029 SHALL, on hs_pulse with fetch_line=0 or shadow enable=0 while in FETCH, continue the current fetch to completion.
REQ-030 SHALL not toggle the bank or advance line_addr for unqualified hs_pulse.
REQ-031 SHALL drive busy=1 exactly when state is FETCH.

Reset
REQ-032 SHALL, while reset_n=0 at posedge clk, set state IDLE, mem_req=0, mem_addr=0, lb_we=0, lb_waddr=0, lb_wdata=0, underrun=0, underrun_cnt=0, busy=0, shadow enable=0, shadow base=0, line_addr=0, bank=0.
REQ-033 SHALL abort any in-progress fetch on reset without a final lb_we or underrun pulse.

Verification
REQ-034 cfg_base=0x1000, enable=1, vs_pulse+hs_pulse+fetch_line, mem_ack tied 1 -> mem_addr 0x1000..0x10BF, 192 lb_we, lb_waddr 0x100..0x1BF, busy falls after last ack.
REQ-035 second qualified hs_pulse after completion -> mem_addr starts at 0x10C0, bank=0 (lb_waddr 0x000..).
REQ-036 mem_ack only every 4th cycle, next hs_pulse after 300 cycles -> underrun pulse once, underrun_cnt=1, new fetch starts at line_addr+192; next vs_pulse clears cnt to 0.
REQ-037 cfg_base changed to 0x2000 mid-frame -> fetch addresses unchanged until next vs_pulse, then start at 0x2000.
REQ-038 reset_n=0 mid-fetch for 1 cycle -> all outputs 0 next cycle, no lb_we, hs_pulse with enable shadow 0 issues no fetch until vs_pulse.
REQ-039 300 forced underruns in one frame -> underrun_cnt holds 255.
